mem_access: RTL and testbench

//  Memory stage of the 5-stage RISC-V core; consumes the EX/MEM register outputs of the execute stage.

---
 rtl/mem_access_if.sv | 20 ++
 rtl/mem_access.sv | 192 +++++++++++++++++++
 tb/tb_mem_access.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_access_if.sv
// Data-memory request/acknowledge bus between the memory stage (master) and data memory (slave).
interface mem_access_if;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_be;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
    input  dmem_ack, dmem_rdata
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
    output dmem_ack, dmem_rdata
  );
endinterface

// File: rtl/mem_access.sv
// Memory stage: issues loads/stores on the req/ack bus, aligns load data, stalls while waiting, and holds MEM/WB.
// Optional MEM_ALIGN_CHECK_EN suppresses misaligned H/W accesses and reports them on o_misalign.
//
// state  | meaning
// S_IDLE | no access outstanding; a new access issues its request here
// S_WAIT | request outstanding, counting cycles toward TIMEOUT
module mem_access #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] i_alu_res,
  input  logic [31:0] i_rs2,
  input  logic        i_mem_w_en,
  input  logic [2:0]  i_func3,
  input  logic [31:0] i_pc4,
  input  logic [4:0]  i_w_idx,
  input  logic [1:0]  i_wb_sel,
  input  logic        i_wb_en,
  mem_access_if.master dmem,
  output logic        o_stall,
  output logic [31:0] o_mem_fw_data,
  output logic [31:0] o_alu_res,
  output logic [31:0] o_load_data,
  output logic [31:0] o_pc4,
  output logic [4:0]  o_w_idx,
  output logic [1:0]  o_wb_sel,
  output logic        o_wb_en,
  output logic        o_bus_err
`ifdef MEM_ALIGN_CHECK_EN
  ,
  output logic        o_misalign
`endif
);

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        bus_err_q, bus_err_d;
  logic [31:0] alu_res_q, alu_res_d;
  logic [31:0] load_data_q, load_data_d;
  logic [31:0] pc4_q, pc4_d;
  logic [4:0]  w_idx_q, w_idx_d;
  logic [1:0]  wb_sel_q, wb_sel_d;
  logic        wb_en_q, wb_en_d;

  logic        access, is_load, misalign, req, abort;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_ext;

  assign access  = i_mem_w_en | (i_wb_en & (i_wb_sel == 2'b01));
  assign is_load = ~i_mem_w_en & i_wb_en & (i_wb_sel == 2'b01);

`ifdef MEM_ALIGN_CHECK_EN
  logic misalign_q, misalign_d;
  assign misalign = access & (((i_func3[1:0] == 2'b01) & i_alu_res[0]) |
                              ((i_func3[1:0] == 2'b10) & (i_alu_res[1:0] != 2'b00)));
`else
  assign misalign = 1'b0;
`endif

  assign req     = rst & (((state_q == S_IDLE) & access & ~misalign) | (state_q == S_WAIT));
  assign abort   = rst & (state_q == S_WAIT) & ~dmem.dmem_ack & (cnt_q == TIMEOUT_CNT);
  assign o_stall = req & ~dmem.dmem_ack & ~abort;

  assign dmem.dmem_req  = req;
  assign dmem.dmem_we   = i_mem_w_en;
  assign dmem.dmem_addr = {i_alu_res[31:2], 2'b00};
  assign o_mem_fw_data  = i_alu_res;

  always_comb begin
    dmem.dmem_be    = 4'b1111;
    dmem.dmem_wdata = i_rs2;
    case (i_func3[1:0])
      2'b00: begin
        dmem.dmem_be    = 4'b0001 << i_alu_res[1:0];
        dmem.dmem_wdata = {4{i_rs2[7:0]}};
      end
      2'b01: begin
        dmem.dmem_be    = i_alu_res[1] ? 4'b1100 : 4'b0011;
        dmem.dmem_wdata = {2{i_rs2[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    byte_sel = dmem.dmem_rdata[7:0];
    case (i_alu_res[1:0])
      2'b01:   byte_sel = dmem.dmem_rdata[15:8];
      2'b10:   byte_sel = dmem.dmem_rdata[23:16];
      2'b11:   byte_sel = dmem.dmem_rdata[31:24];
      default: ;
    endcase
    half_sel = i_alu_res[1] ? dmem.dmem_rdata[31:16] : dmem.dmem_rdata[15:0];
    case (i_func3[1:0])
      2'b00:   load_ext = i_func3[2] ? {24'b0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
      2'b01:   load_ext = i_func3[2] ? {16'b0, half_sel} : {{16{half_sel[15]}}, half_sel};
      default: load_ext = dmem.dmem_rdata;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (access & ~misalign & ~dmem.dmem_ack) begin
          state_d = S_WAIT;
          cnt_d   = 8'd1;
        end
      end
      S_WAIT: begin
        if (dmem.dmem_ack || cnt_q == TIMEOUT_CNT) begin
          state_d = S_IDLE;
          cnt_d   = 8'd0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = 8'd0;
      end
    endcase
  end

  // Stalled cycles insert a bubble; aborted or misaligned loads must not write back.
  always_comb begin
    bus_err_d   = bus_err_q | abort;
    alu_res_d   = i_alu_res;
    load_data_d = load_ext;
    pc4_d       = i_pc4;
    w_idx_d     = i_w_idx;
    wb_sel_d    = i_wb_sel;
    wb_en_d     = i_wb_en & ~((abort | misalign) & is_load);
    if (o_stall) begin
      alu_res_d   = 32'd0;
      load_data_d = 32'd0;
      pc4_d       = 32'd0;
      w_idx_d     = 5'd0;
      wb_sel_d    = 2'd0;
      wb_en_d     = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= 8'd0;
      bus_err_q   <= 1'b0;
      alu_res_q   <= 32'd0;
      load_data_q <= 32'd0;
      pc4_q       <= 32'd0;
      w_idx_q     <= 5'd0;
      wb_sel_q    <= 2'd0;
      wb_en_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bus_err_q   <= bus_err_d;
      alu_res_q   <= alu_res_d;
      load_data_q <= load_data_d;
      pc4_q       <= pc4_d;
      w_idx_q     <= w_idx_d;
      wb_sel_q    <= wb_sel_d;
      wb_en_q     <= wb_en_d;
    end
  end

`ifdef MEM_ALIGN_CHECK_EN
  assign misalign_d = misalign;
  always_ff @(posedge clk) begin
    if (!rst) misalign_q <= 1'b0;
    else      misalign_q <= misalign_d;
  end
  assign o_misalign = misalign_q;
`endif

  assign o_alu_res   = alu_res_q;
  assign o_load_data = load_data_q;
  assign o_pc4       = pc4_q;
  assign o_w_idx     = w_idx_q;
  assign o_wb_sel    = wb_sel_q;
  assign o_wb_en     = wb_en_q;
  assign o_bus_err   = bus_err_q;

endmodule

// File: tb/tb_mem_access.sv
// Directed bench for mem_access (TIMEOUT=4); the misalign scenario follows MEM_ALIGN_CHECK_EN.
module tb_mem_access;
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] i_alu_res, i_rs2, i_pc4;
  logic        i_mem_w_en, i_wb_en;
  logic [2:0]  i_func3;
  logic [4:0]  i_w_idx;
  logic [1:0]  i_wb_sel;
  logic        o_stall, o_wb_en, o_bus_err;
  logic [31:0] o_mem_fw_data, o_alu_res, o_load_data, o_pc4;
  logic [4:0]  o_w_idx;
  logic [1:0]  o_wb_sel;
`ifdef MEM_ALIGN_CHECK_EN
  logic        o_misalign;
`endif
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_access_if bus ();

  mem_access #(.TIMEOUT(4)) dut (
    .clk(clk), .rst(rst),
    .i_alu_res(i_alu_res), .i_rs2(i_rs2), .i_mem_w_en(i_mem_w_en), .i_func3(i_func3),
    .i_pc4(i_pc4), .i_w_idx(i_w_idx), .i_wb_sel(i_wb_sel), .i_wb_en(i_wb_en),
    .dmem(bus),
    .o_stall(o_stall), .o_mem_fw_data(o_mem_fw_data), .o_alu_res(o_alu_res),
    .o_load_data(o_load_data), .o_pc4(o_pc4), .o_w_idx(o_w_idx), .o_wb_sel(o_wb_sel),
    .o_wb_en(o_wb_en), .o_bus_err(o_bus_err)
`ifdef MEM_ALIGN_CHECK_EN
    , .o_misalign(o_misalign)
`endif
  );

  task automatic set_idle();
    i_alu_res = 0; i_rs2 = 0; i_pc4 = 0; i_mem_w_en = 0; i_wb_en = 0;
    i_func3 = 0; i_w_idx = 0; i_wb_sel = 0;
    bus.dmem_ack = 0; bus.dmem_rdata = 0;
  endtask

  task automatic drive_load(input logic [31:0] addr, input logic [2:0] f3, input logic [4:0] idx);
    i_alu_res = addr; i_rs2 = 0; i_pc4 = addr + 32'h1000; i_mem_w_en = 0;
    i_wb_en = 1; i_wb_sel = 2'b01; i_func3 = f3; i_w_idx = idx;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 0; set_idle();
    drive_load(32'h100, 3'b010, 5'd3);
    #1;
    checks++; if (bus.dmem_req !== 1'b0) begin errors++; $display("FAIL reset_req got %b exp 0", bus.dmem_req); end
    checks++; if (o_stall !== 1'b0) begin errors++; $display("FAIL reset_stall got %b exp 0", o_stall); end
    @(posedge clk); #1;
    checks++; if ({o_wb_en, o_w_idx, o_alu_res, o_load_data, o_bus_err} !== '0)
      begin errors++; $display("FAIL reset_regs got wb_en=%b idx=%0d alu=%h ld=%h err=%b exp all 0",
                               o_wb_en, o_w_idx, o_alu_res, o_load_data, o_bus_err); end
    @(negedge clk);
    rst = 1; set_idle();
  endtask

  task automatic test_lw_zero_wait();
    @(negedge clk);
    set_idle();
    drive_load(32'h100, 3'b010, 5'd5);
    bus.dmem_ack = 1; bus.dmem_rdata = 32'hDEADBEEF;
    #1;
    checks++; if ({bus.dmem_req, bus.dmem_we, o_stall} !== 3'b100)
      begin errors++; $display("FAIL lw_bus req/we/stall got %b exp 100", {bus.dmem_req, bus.dmem_we, o_stall}); end
    checks++; if (bus.dmem_addr !== 32'h100 || bus.dmem_be !== 4'b1111 || o_mem_fw_data !== 32'h100)
      begin errors++; $display("FAIL lw_addr got addr=%h be=%b fw=%h exp 100/1111/100", bus.dmem_addr, bus.dmem_be, o_mem_fw_data); end
    @(posedge clk); #1;
    checks++; if (o_load_data !== 32'hDEADBEEF || o_wb_en !== 1'b1 || o_w_idx !== 5'd5 || o_wb_sel !== 2'b01 || o_pc4 !== 32'h1100)
      begin errors++; $display("FAIL lw_wb got ld=%h en=%b idx=%0d sel=%b pc4=%h exp deadbeef/1/5/01/1100",
                               o_load_data, o_wb_en, o_w_idx, o_wb_sel, o_pc4); end
  endtask

  task automatic test_lb_wait(input logic [2:0] f3, input logic [31:0] exp_data);
    @(negedge clk);
    set_idle();
    drive_load(32'h103, f3, 5'd6);
    bus.dmem_rdata = 32'h80123456;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (o_stall !== 1'b1) begin errors++; $display("FAIL lb_stall cyc %0d got %b exp 1", i, o_stall); end
      @(posedge clk); #1;
      checks++; if (o_wb_en !== 1'b0 || o_w_idx !== 5'd0 || o_alu_res !== 32'd0)
        begin errors++; $display("FAIL lb_bubble cyc %0d got en=%b idx=%0d alu=%h exp 0", i, o_wb_en, o_w_idx, o_alu_res); end
      @(negedge clk);
    end
    bus.dmem_ack = 1;
    #1;
    checks++; if (o_stall !== 1'b0) begin errors++; $display("FAIL lb_ack_stall got %b exp 0", o_stall); end
    @(posedge clk); #1;
    checks++; if (o_load_data !== exp_data || o_wb_en !== 1'b1 || o_w_idx !== 5'd6)
      begin errors++; $display("FAIL lb_data f3=%b got ld=%h en=%b idx=%0d exp %h/1/6", f3, o_load_data, o_wb_en, o_w_idx, exp_data); end
  endtask

  task automatic test_store();
    logic [31:0] addrs [3] = '{32'h202, 32'h201, 32'h300};
    logic [2:0]  f3s   [3] = '{3'b001, 3'b000, 3'b010};
    logic [3:0]  bes   [3] = '{4'b1100, 4'b0010, 4'b1111};
    logic [31:0] wds   [3] = '{32'hABCDABCD, 32'hCDCDCDCD, 32'h1234ABCD};
    logic [31:0] bas   [3] = '{32'h200, 32'h200, 32'h300};
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      set_idle();
      i_alu_res = addrs[i]; i_rs2 = 32'h1234ABCD; i_mem_w_en = 1; i_func3 = f3s[i];
      bus.dmem_ack = 1;
      #1;
      checks++; if (bus.dmem_be !== bes[i] || bus.dmem_wdata !== wds[i] || bus.dmem_we !== 1'b1 ||
                    bus.dmem_addr !== bas[i] || bus.dmem_req !== 1'b1 || o_stall !== 1'b0)
        begin errors++; $display("FAIL store%0d got be=%b wd=%h we=%b addr=%h req=%b stall=%b exp be=%b wd=%h we=1 addr=%h req=1 stall=0",
                                 i, bus.dmem_be, bus.dmem_wdata, bus.dmem_we, bus.dmem_addr, bus.dmem_req, o_stall,
                                 bes[i], wds[i], bas[i]); end
      @(posedge clk); #1;
      checks++; if (o_wb_en !== 1'b0 || o_alu_res !== addrs[i])
        begin errors++; $display("FAIL store%0d_wb got en=%b alu=%h exp 0/%h", i, o_wb_en, o_alu_res, addrs[i]); end
    end
  endtask

  task automatic test_half_ext();
    logic [31:0] addrs [3] = '{32'h102, 32'h102, 32'h100};
    logic [2:0]  f3s   [3] = '{3'b001, 3'b101, 3'b001};
    logic [31:0] exps  [3] = '{32'hFFFF8001, 32'h00008001, 32'h00007FFF};
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      set_idle();
      drive_load(addrs[i], f3s[i], 5'd10);
      bus.dmem_ack = 1; bus.dmem_rdata = 32'h80017FFF;
      @(posedge clk); #1;
      checks++; if (o_load_data !== exps[i] || o_wb_en !== 1'b1)
        begin errors++; $display("FAIL half%0d got ld=%h en=%b exp %h/1", i, o_load_data, o_wb_en, exps[i]); end
    end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    set_idle();
    drive_load(32'h100, 3'b010, 5'd1);
    bus.dmem_ack = 1; bus.dmem_rdata = 32'h11223344;
    @(posedge clk); #1;
    checks++; if (o_load_data !== 32'h11223344 || o_w_idx !== 5'd1)
      begin errors++; $display("FAIL b2b_first got ld=%h idx=%0d exp 11223344/1", o_load_data, o_w_idx); end
    @(negedge clk);
    drive_load(32'h101, 3'b100, 5'd2);
    bus.dmem_rdata = 32'h0000AB00;
    #1;
    checks++; if (o_stall !== 1'b0) begin errors++; $display("FAIL b2b_stall got %b exp 0", o_stall); end
    @(posedge clk); #1;
    checks++; if (o_load_data !== 32'h000000AB || o_w_idx !== 5'd2 || o_wb_en !== 1'b1)
      begin errors++; $display("FAIL b2b_second got ld=%h idx=%0d en=%b exp 000000ab/2/1", o_load_data, o_w_idx, o_wb_en); end
  endtask

  task automatic test_timeout();
    @(negedge clk);
    set_idle();
    drive_load(32'h400, 3'b010, 5'd7);
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++; if (o_stall !== 1'b1 || o_bus_err !== 1'b0)
        begin errors++; $display("FAIL to_stall cyc %0d got stall=%b err=%b exp 1/0", i, o_stall, o_bus_err); end
      @(posedge clk);
      @(negedge clk);
    end
    #1;
    checks++; if (o_stall !== 1'b0 || bus.dmem_req !== 1'b1)
      begin errors++; $display("FAIL to_abort got stall=%b req=%b exp 0/1", o_stall, bus.dmem_req); end
    @(posedge clk); #1;
    checks++; if (o_bus_err !== 1'b1 || o_wb_en !== 1'b0 || o_w_idx !== 5'd7 || o_alu_res !== 32'h400)
      begin errors++; $display("FAIL to_wb got err=%b en=%b idx=%0d alu=%h exp 1/0/7/400", o_bus_err, o_wb_en, o_w_idx, o_alu_res); end
    @(negedge clk);
    set_idle();
    #1;
    checks++; if (bus.dmem_req !== 1'b0) begin errors++; $display("FAIL to_idle_req got %b exp 0", bus.dmem_req); end
    @(posedge clk); #1;
    checks++; if (o_bus_err !== 1'b1) begin errors++; $display("FAIL to_sticky got %b exp 1", o_bus_err); end
  endtask

  task automatic test_reset_mid_wait();
    @(negedge clk);
    set_idle();
    drive_load(32'h500, 3'b010, 5'd9);
    @(posedge clk);
    @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 0;
    #1;
    checks++; if (bus.dmem_req !== 1'b0 || o_stall !== 1'b0)
      begin errors++; $display("FAIL rmw_comb got req=%b stall=%b exp 0/0", bus.dmem_req, o_stall); end
    @(posedge clk); #1;
    checks++; if ({o_wb_en, o_w_idx, o_alu_res, o_pc4, o_bus_err} !== '0)
      begin errors++; $display("FAIL rmw_regs got en=%b idx=%0d alu=%h pc4=%h err=%b exp all 0",
                               o_wb_en, o_w_idx, o_alu_res, o_pc4, o_bus_err); end
    @(negedge clk);
    rst = 1; set_idle();
    bus.dmem_ack = 1; bus.dmem_rdata = 32'h12345678;
    #1;
    checks++; if (bus.dmem_req !== 1'b0 || o_stall !== 1'b0)
      begin errors++; $display("FAIL rmw_late_ack got req=%b stall=%b exp 0/0", bus.dmem_req, o_stall); end
    @(posedge clk); #1;
    checks++; if (o_wb_en !== 1'b0 || o_bus_err !== 1'b0)
      begin errors++; $display("FAIL rmw_late_wb got en=%b err=%b exp 0/0", o_wb_en, o_bus_err); end
    @(negedge clk);
    set_idle();
    drive_load(32'h600, 3'b010, 5'd4);
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++; if (o_stall !== 1'b1) begin errors++; $display("FAIL rmw_restart cyc %0d got %b exp 1", i, o_stall); end
      @(posedge clk);
      @(negedge clk);
    end
    #1;
    checks++; if (o_stall !== 1'b0) begin errors++; $display("FAIL rmw_restart_abort got %b exp 0", o_stall); end
    @(posedge clk);
  endtask

  task automatic test_misalign();
    @(negedge clk);
    set_idle();
    drive_load(32'h101, 3'b010, 5'd8);
    bus.dmem_rdata = 32'hCAFEF00D;
    #1;
`ifdef MEM_ALIGN_CHECK_EN
    checks++; if (bus.dmem_req !== 1'b0 || o_stall !== 1'b0)
      begin errors++; $display("FAIL mis_req got req=%b stall=%b exp 0/0", bus.dmem_req, o_stall); end
    @(posedge clk); #1;
    checks++; if (o_misalign !== 1'b1 || o_wb_en !== 1'b0)
      begin errors++; $display("FAIL mis_pulse got mis=%b en=%b exp 1/0", o_misalign, o_wb_en); end
    @(negedge clk);
    set_idle();
    @(posedge clk); #1;
    checks++; if (o_misalign !== 1'b0) begin errors++; $display("FAIL mis_clear got %b exp 0", o_misalign); end
`else
    checks++; if (bus.dmem_be !== 4'b1111 || bus.dmem_addr !== 32'h100 || bus.dmem_req !== 1'b1)
      begin errors++; $display("FAIL mis_noalign got be=%b addr=%h req=%b exp 1111/100/1", bus.dmem_be, bus.dmem_addr, bus.dmem_req); end
    bus.dmem_ack = 1;
    @(posedge clk); #1;
    checks++; if (o_load_data !== 32'hCAFEF00D || o_wb_en !== 1'b1)
      begin errors++; $display("FAIL mis_noalign_wb got ld=%h en=%b exp cafef00d/1", o_load_data, o_wb_en); end
`endif
  endtask

  initial begin
    rst = 0;
    set_idle();
    test_reset();
    test_lw_zero_wait();
    test_lb_wait(3'b000, 32'hFFFFFF80);
    test_lb_wait(3'b100, 32'h00000080);
    test_store();
    test_half_ext();
    test_back_to_back();
    test_misalign();
    test_timeout();
    test_reset_mid_wait();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
endmodule
